// File: rtl/morty_pkg.sv
// Shared Morty pipeline definitions: memory access sizes, memory trap codes, MEM-stage states.
package morty_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [3:0] LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] LOAD_FAULT     = 4'd5;
  localparam logic [3:0] STORE_MISALIGN = 4'd6;
  localparam logic [3:0] STORE_FAULT    = 4'd7;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: store sel/wdata from the request,
// and load extraction plus sign/zero extension from the returned word.
module mem_lane_align
  import morty_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [31:0] shifted;

  always_comb begin
    sel_o   = 4'b1111;
    wdata_o = st_data_i;
    case (st_size_i)
      SIZE_B: begin
        sel_o   = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      SIZE_H: begin
        sel_o   = 4'b0011 << st_off_i;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        sel_o   = 4'b1111;
        wdata_o = st_data_i;
      end
    endcase
  end

  always_comb begin
    shifted = rdata_i >> {ld_off_i, 3'b000};
    ldata_o = shifted;
    case (ld_size_i)
      SIZE_B:  ldata_o = ld_unsigned_i ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  ldata_o = ld_unsigned_i ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: ldata_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Morty MEM stage: runs loads/stores on an ack-based data bus, registers EX/MEM results.
// Latency 1 cycle for non-memory ops, >=2 for bus ops; stall_o holds EX while a bus access is pending.
module mem_stage
  import morty_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        valid_ex_i,
  input  logic [31:0] alu_out_ex_i,
  input  logic [31:0] rs2_data_ex_i,
  input  logic [4:0]  rd_ex_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [3:0]  trap_code_ex_i,
  input  logic        is_trap_ex_i,
  input  logic [31:0] PC_ex_i,
  input  logic [31:0] PC4_ex_i,
  input  logic [31:0] csr_data_ex_i,
  input  logic [11:0] csr_addr_ex_i,
  input  logic        is_rs0_i,
  output logic        stall_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_sel_o,
  output logic        dbus_we_o,
  output logic        dbus_cyc_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  input  logic        dbus_err_i,
  output logic        valid_mem_o,
  output logic [31:0] result_mem_o,
  output logic [4:0]  rd_mem_o,
  output logic [3:0]  trap_code_mem_o,
  output logic        is_trap_mem_o,
  output logic [31:0] PC_mem_o,
  output logic [31:0] PC4_mem_o,
  output logic [31:0] csr_data_mem_o,
  output logic [11:0] csr_addr_mem_o,
  output logic        is_rs0_mem_o
);

  mem_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  // Request captured at issue; EX inputs are not trusted while in BUS.
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        store_q;
  logic [4:0]  rd_lat_q;
  logic [31:0] pc_lat_q, pc4_lat_q, csr_data_lat_q;
  logic [11:0] csr_addr_lat_q;
  logic        is_rs0_lat_q;

  logic [31:0] dbus_addr_q, dbus_wdata_q;
  logic [3:0]  dbus_sel_q;
  logic        dbus_we_q, dbus_cyc_q;

  logic        valid_q;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  code_q, code_d;
  logic        trap_q, trap_d;
  logic [31:0] pc_q, pc_d, pc4_q, pc4_d, csr_data_q, csr_data_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic        is_rs0_q, is_rs0_d;

  logic        is_mem, misalign, timeout, done, issue, consume;
  logic [3:0]  sel_w;
  logic [31:0] wdata_w, ldata_w;

  mem_lane_align u_align (
    .st_off_i      (alu_out_ex_i[1:0]),
    .st_size_i     (mem_size_i),
    .st_data_i     (rs2_data_ex_i),
    .sel_o         (sel_w),
    .wdata_o       (wdata_w),
    .ld_off_i      (addr_q[1:0]),
    .ld_size_i     (size_q),
    .ld_unsigned_i (unsigned_q),
    .rdata_i       (dbus_rdata_i),
    .ldata_o       (ldata_w)
  );

  always_comb begin
    is_mem   = mem_re_i | mem_we_i;
    misalign = ((mem_size_i == SIZE_H) && alu_out_ex_i[0]) ||
               (mem_size_i[1] && (alu_out_ex_i[1:0] != 2'b00));
    timeout  = (cnt_q == 16'(MAX_WAIT - 1));
    done     = dbus_ack_i | dbus_err_i | timeout;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_o    = 1'b0;
    issue      = 1'b0;
    consume    = 1'b0;
    result_d   = alu_out_ex_i;
    rd_d       = rd_ex_i;
    code_d     = trap_code_ex_i;
    trap_d     = is_trap_ex_i;
    pc_d       = PC_ex_i;
    pc4_d      = PC4_ex_i;
    csr_data_d = csr_data_ex_i;
    csr_addr_d = csr_addr_ex_i;
    is_rs0_d   = is_rs0_i;
    case (state_q)
      IDLE: begin
        if (valid_ex_i && is_mem && !is_trap_ex_i && !misalign) begin
          stall_o = 1'b1;
          issue   = 1'b1;
          state_d = BUS;
          cnt_d   = 16'd0;
        end else if (valid_ex_i) begin
          consume = 1'b1;
          if (is_mem && !is_trap_ex_i) begin
            trap_d = 1'b1;
            code_d = mem_we_i ? STORE_MISALIGN : LOAD_MISALIGN;
          end
        end
      end
      BUS: begin
        stall_o    = ~done;
        rd_d       = rd_lat_q;
        pc_d       = pc_lat_q;
        pc4_d      = pc4_lat_q;
        csr_data_d = csr_data_lat_q;
        csr_addr_d = csr_addr_lat_q;
        is_rs0_d   = is_rs0_lat_q;
        trap_d     = 1'b0;
        code_d     = 4'd0;
        result_d   = addr_q;
        if (!done) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          consume = 1'b1;
          state_d = IDLE;
          // ack wins over err when both arrive together
          if (dbus_ack_i) begin
            if (!store_q) result_d = ldata_w;
          end else begin
            trap_d = 1'b1;
            code_d = store_q ? STORE_FAULT : LOAD_FAULT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q        <= IDLE;
      cnt_q          <= 16'd0;
      addr_q         <= 32'h0;
      size_q         <= 2'b00;
      unsigned_q     <= 1'b0;
      store_q        <= 1'b0;
      rd_lat_q       <= 5'd0;
      pc_lat_q       <= 32'h0;
      pc4_lat_q      <= 32'h0;
      csr_data_lat_q <= 32'h0;
      csr_addr_lat_q <= 12'h0;
      is_rs0_lat_q   <= 1'b0;
      dbus_addr_q    <= 32'h0;
      dbus_wdata_q   <= 32'h0;
      dbus_sel_q     <= 4'h0;
      dbus_we_q      <= 1'b0;
      dbus_cyc_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (issue) begin
        addr_q         <= alu_out_ex_i;
        size_q         <= mem_size_i;
        unsigned_q     <= mem_unsigned_i;
        store_q        <= mem_we_i;
        rd_lat_q       <= rd_ex_i;
        pc_lat_q       <= PC_ex_i;
        pc4_lat_q      <= PC4_ex_i;
        csr_data_lat_q <= csr_data_ex_i;
        csr_addr_lat_q <= csr_addr_ex_i;
        is_rs0_lat_q   <= is_rs0_i;
        dbus_addr_q    <= {alu_out_ex_i[31:2], 2'b00};
        dbus_wdata_q   <= wdata_w;
        dbus_sel_q     <= sel_w;
        dbus_we_q      <= mem_we_i;
        dbus_cyc_q     <= 1'b1;
      end else if (state_q == BUS && done) begin
        dbus_cyc_q <= 1'b0;
        dbus_we_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q    <= 1'b0;
      result_q   <= 32'h0;
      rd_q       <= 5'd0;
      code_q     <= 4'd0;
      trap_q     <= 1'b0;
      pc_q       <= 32'h0;
      pc4_q      <= 32'h0;
      csr_data_q <= 32'h0;
      csr_addr_q <= 12'h0;
      is_rs0_q   <= 1'b0;
    end else begin
      valid_q <= consume;
      if (consume) begin
        result_q   <= result_d;
        rd_q       <= rd_d;
        code_q     <= code_d;
        trap_q     <= trap_d;
        pc_q       <= pc_d;
        pc4_q      <= pc4_d;
        csr_data_q <= csr_data_d;
        csr_addr_q <= csr_addr_d;
        is_rs0_q   <= is_rs0_d;
      end
    end
  end

  assign dbus_addr_o     = dbus_addr_q;
  assign dbus_wdata_o    = dbus_wdata_q;
  assign dbus_sel_o      = dbus_sel_q;
  assign dbus_we_o       = dbus_we_q;
  assign dbus_cyc_o      = dbus_cyc_q;
  assign valid_mem_o     = valid_q;
  assign result_mem_o    = result_q;
  assign rd_mem_o        = rd_q;
  assign trap_code_mem_o = code_q;
  assign is_trap_mem_o   = trap_q;
  assign PC_mem_o        = pc_q;
  assign PC4_mem_o       = pc4_q;
  assign csr_data_mem_o  = csr_data_q;
  assign csr_addr_mem_o  = csr_addr_q;
  assign is_rs0_mem_o    = is_rs0_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads/stores, misalign and fault traps, reset mid-access.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        valid_ex_i;
  logic [31:0] alu_out_ex_i, rs2_data_ex_i;
  logic [4:0]  rd_ex_i;
  logic        mem_re_i, mem_we_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [3:0]  trap_code_ex_i;
  logic        is_trap_ex_i;
  logic [31:0] PC_ex_i, PC4_ex_i, csr_data_ex_i;
  logic [11:0] csr_addr_ex_i;
  logic        is_rs0_i;
  logic        stall_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_sel_o;
  logic        dbus_we_o, dbus_cyc_o;
  logic [31:0] dbus_rdata_i;
  logic        dbus_ack_i, dbus_err_i;
  logic        valid_mem_o;
  logic [31:0] result_mem_o;
  logic [4:0]  rd_mem_o;
  logic [3:0]  trap_code_mem_o;
  logic        is_trap_mem_o;
  logic [31:0] PC_mem_o, PC4_mem_o, csr_data_mem_o;
  logic [11:0] csr_addr_mem_o;
  logic        is_rs0_mem_o;

  int checks = 0;
  int errors = 0;

  mem_stage #(.MAX_WAIT(255)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_ex_i(valid_ex_i),
    .alu_out_ex_i(alu_out_ex_i), .rs2_data_ex_i(rs2_data_ex_i), .rd_ex_i(rd_ex_i),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_unsigned_i(mem_unsigned_i), .trap_code_ex_i(trap_code_ex_i),
    .is_trap_ex_i(is_trap_ex_i), .PC_ex_i(PC_ex_i), .PC4_ex_i(PC4_ex_i),
    .csr_data_ex_i(csr_data_ex_i), .csr_addr_ex_i(csr_addr_ex_i), .is_rs0_i(is_rs0_i),
    .stall_o(stall_o), .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_sel_o(dbus_sel_o), .dbus_we_o(dbus_we_o), .dbus_cyc_o(dbus_cyc_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i),
    .valid_mem_o(valid_mem_o), .result_mem_o(result_mem_o), .rd_mem_o(rd_mem_o),
    .trap_code_mem_o(trap_code_mem_o), .is_trap_mem_o(is_trap_mem_o),
    .PC_mem_o(PC_mem_o), .PC4_mem_o(PC4_mem_o), .csr_data_mem_o(csr_data_mem_o),
    .csr_addr_mem_o(csr_addr_mem_o), .is_rs0_mem_o(is_rs0_mem_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_ex_i = 0; alu_out_ex_i = 0; rs2_data_ex_i = 0; rd_ex_i = 0;
    mem_re_i = 0; mem_we_i = 0; mem_size_i = 2'b10; mem_unsigned_i = 0;
    trap_code_ex_i = 0; is_trap_ex_i = 0; PC_ex_i = 0; PC4_ex_i = 0;
    csr_data_ex_i = 0; csr_addr_ex_i = 0; is_rs0_i = 0;
    dbus_rdata_i = 0; dbus_ack_i = 0; dbus_err_i = 0;
  endtask

  task automatic present(input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic re, input logic we, input logic [1:0] size, input logic uns);
    valid_ex_i = 1; alu_out_ex_i = addr; rs2_data_ex_i = rs2; rd_ex_i = rd;
    mem_re_i = re; mem_we_i = we; mem_size_i = size; mem_unsigned_i = uns;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn_i = 0;
    #12;
    checks++; if (dbus_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b want 0", dbus_cyc_o); end
    checks++; if (valid_mem_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_mem_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_o); end
    checks++; if ({dbus_addr_o, dbus_wdata_o, dbus_sel_o, result_mem_o} !== 100'h0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h/%h want 0", dbus_addr_o, dbus_wdata_o, dbus_sel_o, result_mem_o);
    end
    @(negedge clk_i);
    rstn_i = 1;
    tick();
  endtask

  task automatic test_alu();
    PC_ex_i = 32'h0000_0040; PC4_ex_i = 32'h0000_0044; is_rs0_i = 1; csr_addr_ex_i = 12'h305;
    present(32'h0000_1234, 32'h0, 5'd3, 0, 0, 2'b10, 0);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", stall_o); end
    tick();
    idle_inputs();
    checks++; if (valid_mem_o !== 1'b1 || result_mem_o !== 32'h0000_1234 || rd_mem_o !== 5'd3) begin
      errors++; $display("FAIL alu_result got v=%b r=%h rd=%0d want v=1 r=00001234 rd=3", valid_mem_o, result_mem_o, rd_mem_o);
    end
    checks++; if (PC_mem_o !== 32'h40 || PC4_mem_o !== 32'h44 || is_rs0_mem_o !== 1'b1 || csr_addr_mem_o !== 12'h305) begin
      errors++; $display("FAIL alu_passthru got pc=%h pc4=%h rs0=%b csr=%h", PC_mem_o, PC4_mem_o, is_rs0_mem_o, csr_addr_mem_o);
    end
    checks++; if (dbus_cyc_o !== 1'b0) begin errors++; $display("FAIL alu_cyc got %b want 0", dbus_cyc_o); end
    tick();
    checks++; if (valid_mem_o !== 1'b0) begin errors++; $display("FAIL alu_bubble got %b want 0", valid_mem_o); end
  endtask

  task automatic test_back_to_back();
    present(32'h0000_0011, 32'h0, 5'd1, 0, 0, 2'b10, 0);
    tick();
    present(32'h0000_0022, 32'h0, 5'd2, 0, 0, 2'b10, 0);
    checks++; if (valid_mem_o !== 1'b1 || result_mem_o !== 32'h11) begin
      errors++; $display("FAIL b2b_first got v=%b r=%h want 1/00000011", valid_mem_o, result_mem_o);
    end
    tick();
    idle_inputs();
    checks++; if (valid_mem_o !== 1'b1 || result_mem_o !== 32'h22 || rd_mem_o !== 5'd2) begin
      errors++; $display("FAIL b2b_second got v=%b r=%h rd=%0d want 1/00000022/2", valid_mem_o, result_mem_o, rd_mem_o);
    end
    tick();
  endtask

  task automatic test_lb();
    int stalls;
    PC_ex_i = 32'h0000_0100;
    present(32'h0000_0103, 32'h0, 5'd5, 1, 0, 2'b00, 0);
    stalls = stall_o ? 1 : 0;
    tick();
    checks++; if (dbus_cyc_o !== 1'b1 || dbus_sel_o !== 4'b1000 || dbus_addr_o !== 32'h100 || dbus_we_o !== 1'b0) begin
      errors++; $display("FAIL lb_bus got cyc=%b sel=%b addr=%h we=%b want 1/1000/00000100/0", dbus_cyc_o, dbus_sel_o, dbus_addr_o, dbus_we_o);
    end
    PC_ex_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      if (stall_o) stalls++;
      tick();
    end
    dbus_rdata_i = 32'h80FF_0000; dbus_ack_i = 1;
    #1;
    if (stall_o) stalls++;
    checks++; if (stalls !== 4) begin errors++; $display("FAIL lb_stall_cycles got %0d want 4", stalls); end
    tick();
    idle_inputs();
    checks++; if (valid_mem_o !== 1'b1 || result_mem_o !== 32'hFFFF_FF80 || rd_mem_o !== 5'd5 || is_trap_mem_o !== 1'b0) begin
      errors++; $display("FAIL lb_result got v=%b r=%h rd=%0d t=%b want 1/ffffff80/5/0", valid_mem_o, result_mem_o, rd_mem_o, is_trap_mem_o);
    end
    checks++; if (PC_mem_o !== 32'h100 || dbus_cyc_o !== 1'b0) begin
      errors++; $display("FAIL lb_latched got pc=%h cyc=%b want 00000100/0", PC_mem_o, dbus_cyc_o);
    end
    tick();
  endtask

  task automatic test_lbu_lh();
    present(32'h0000_0302, 32'h0, 5'd7, 1, 0, 2'b01, 1);
    tick();
    dbus_rdata_i = 32'h9ABC_1234; dbus_ack_i = 1;
    tick();
    idle_inputs();
    checks++; if (valid_mem_o !== 1'b1 || result_mem_o !== 32'h0000_9ABC) begin
      errors++; $display("FAIL lhu_result got v=%b r=%h want 1/00009abc", valid_mem_o, result_mem_o);
    end
    tick();
  endtask

  task automatic test_sh();
    present(32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 0, 1, 2'b01, 0);
    tick();
    checks++; if (dbus_addr_o !== 32'h200 || dbus_sel_o !== 4'b1100 || dbus_wdata_o !== 32'hBEEF_BEEF || dbus_we_o !== 1'b1 || dbus_cyc_o !== 1'b1) begin
      errors++; $display("FAIL sh_bus got addr=%h sel=%b wd=%h we=%b cyc=%b", dbus_addr_o, dbus_sel_o, dbus_wdata_o, dbus_we_o, dbus_cyc_o);
    end
    dbus_ack_i = 1;
    tick();
    idle_inputs();
    checks++; if (valid_mem_o !== 1'b1 || result_mem_o !== 32'h202 || is_trap_mem_o !== 1'b0 || dbus_cyc_o !== 1'b0) begin
      errors++; $display("FAIL sh_result got v=%b r=%h t=%b cyc=%b want 1/00000202/0/0", valid_mem_o, result_mem_o, is_trap_mem_o, dbus_cyc_o);
    end
    tick();
  endtask

  task automatic test_misalign();
    present(32'h0000_0101, 32'h0, 5'd9, 1, 0, 2'b10, 0);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lw_mis_stall got %b want 0", stall_o); end
    tick();
    idle_inputs();
    checks++; if (valid_mem_o !== 1'b1 || is_trap_mem_o !== 1'b1 || trap_code_mem_o !== 4'd4 || dbus_cyc_o !== 1'b0) begin
      errors++; $display("FAIL lw_misalign got v=%b t=%b c=%0d cyc=%b want 1/1/4/0", valid_mem_o, is_trap_mem_o, trap_code_mem_o, dbus_cyc_o);
    end
    present(32'h0000_0203, 32'h0, 5'd9, 0, 1, 2'b01, 0);
    tick();
    idle_inputs();
    checks++; if (is_trap_mem_o !== 1'b1 || trap_code_mem_o !== 4'd6 || dbus_cyc_o !== 1'b0) begin
      errors++; $display("FAIL sh_misalign got t=%b c=%0d cyc=%b want 1/6/0", is_trap_mem_o, trap_code_mem_o, dbus_cyc_o);
    end
    is_trap_ex_i = 1; trap_code_ex_i = 4'd2;
    present(32'h0000_0400, 32'h0, 5'd4, 1, 0, 2'b10, 0);
    tick();
    idle_inputs();
    checks++; if (is_trap_mem_o !== 1'b1 || trap_code_mem_o !== 4'd2 || dbus_cyc_o !== 1'b0 || valid_mem_o !== 1'b1) begin
      errors++; $display("FAIL upstream_trap got t=%b c=%0d cyc=%b v=%b want 1/2/0/1", is_trap_mem_o, trap_code_mem_o, dbus_cyc_o, valid_mem_o);
    end
    tick();
  endtask

  task automatic test_err();
    present(32'h0000_0400, 32'h0, 5'd12, 1, 0, 2'b10, 0);
    tick();
    dbus_err_i = 1;
    tick();
    idle_inputs();
    checks++; if (is_trap_mem_o !== 1'b1 || trap_code_mem_o !== 4'd5 || rd_mem_o !== 5'd12 || valid_mem_o !== 1'b1) begin
      errors++; $display("FAIL lw_err got t=%b c=%0d rd=%0d v=%b want 1/5/12/1", is_trap_mem_o, trap_code_mem_o, rd_mem_o, valid_mem_o);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    present(32'h0000_0300, 32'h1234_5678, 5'd0, 0, 1, 2'b10, 0);
    tick();
    n = 1;
    while (stall_o === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    checks++; if (n !== 255) begin errors++; $display("FAIL sw_timeout_cycles got %0d want 255", n); end
    tick();
    idle_inputs();
    checks++; if (valid_mem_o !== 1'b1 || is_trap_mem_o !== 1'b1 || trap_code_mem_o !== 4'd7 || dbus_cyc_o !== 1'b0) begin
      errors++; $display("FAIL sw_timeout got v=%b t=%b c=%0d cyc=%b want 1/1/7/0", valid_mem_o, is_trap_mem_o, trap_code_mem_o, dbus_cyc_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    present(32'h0000_0500, 32'h0, 5'd6, 1, 0, 2'b10, 0);
    tick();
    checks++; if (dbus_cyc_o !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b want 1", dbus_cyc_o); end
    #1;
    rstn_i = 0;
    #1;
    checks++; if (dbus_cyc_o !== 1'b0 || stall_o !== 1'b0 && valid_ex_i === 1'b0) begin
      errors++; $display("FAIL rst_mid_cyc got %b want 0", dbus_cyc_o);
    end
    idle_inputs();
    @(negedge clk_i);
    rstn_i = 1;
    tick();
    checks++; if (valid_mem_o !== 1'b0) begin errors++; $display("FAIL rst_mid_noresult got %b want 0", valid_mem_o); end
    present(32'h0000_0504, 32'h0, 5'd8, 1, 0, 2'b10, 0);
    tick();
    dbus_rdata_i = 32'hCAFE_BABE; dbus_ack_i = 1;
    tick();
    idle_inputs();
    checks++; if (valid_mem_o !== 1'b1 || result_mem_o !== 32'hCAFE_BABE || rd_mem_o !== 5'd8 || is_trap_mem_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_lw got v=%b r=%h rd=%0d t=%b want 1/cafebabe/8/0", valid_mem_o, result_mem_o, rd_mem_o, is_trap_mem_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_lb();
    test_lbu_lh();
    test_sh();
    test_misalign();
    test_err();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
